alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one 16-bit combinational alu between two requesters (e.g. fetch/decode unit, debug port).
//  Round-robin arbitration, valid/ready handshakes on request and response sides.
//  Operands and opcode are registered; the alu is driven from registers; the result is captured after a settle count.
//  Sits between the requesters and the single alu instance; owns the alu a/b/s inputs.
// PARAMETERS
//  WIDTH          16  operand/result width; must match alu
//  SETTLE_CYCLES  1   cycles (>=1) the alu inputs are held stable before the result is captured
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  req_valid    in   2      bit i: requester i has an operation pending
//  req_ready    out  2      bit i: operation of requester i accepted this cycle (one-hot or 0)
//  req0_a/req0_b in  WIDTH  requester 0 operands
//  req0_op      in   4      requester 0 alu opcode (alu s encoding)
//  req1_a/req1_b in  WIDTH  requester 1 operands
//  req1_op      in   4      requester 1 alu opcode
//  resp_valid   out  2      bit i: result for requester i is available; held until accepted
//  resp_ready   in   2      bit i: requester i takes the result
//  resp_result  out  WIDTH  captured alu result (shared by both requesters; qualified by resp_valid)
//  resp_zero    out  1      1 when resp_result == 0
//  alu_a/alu_b  out  WIDTH  to alu a/b
//  alu_s        out  4      to alu s
//  alu_result   in   WIDTH  from alu result
//  busy         out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req_ready=0, resp_valid=0, resp_result=0, resp_zero=0,
//   alu_a=alu_b=0, alu_s=4'b0000, busy=0, settle counter=0. Reset mid-operation drops the op; no response is issued.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: if |req_valid: grant g (rr rule), req_ready[g]=1 combinationally this cycle, latch
//   reqg_a/b/op into alu_a/alu_b/alu_s, record owner=g, counter=SETTLE_CYCLES-1, go WAIT. Else stay.
//  Arbitration: only one valid -> that one. Both valid -> requester at rr pointer. On grant, pointer <= ~g.
//  WAIT: alu_* held constant. counter==0 -> resp_result<=alu_result, resp_zero<=(alu_result==0), go RESP;
//   else counter decrements.
//  RESP: resp_valid[owner]=1 (registered), other bit 0. resp_ready[owner]=1 -> resp_valid cleared next cycle,
//   go IDLE. resp_ready on non-owner bit is ignored. resp_result/resp_zero hold until next capture.
//  req_ready is 0 outside IDLE; no new request is accepted until the response is taken (single outstanding op).
//  Latency: accept edge T -> resp_valid high at T+SETTLE_CYCLES+1. Min issue interval: SETTLE_CYCLES+2 cycles.
//  Opcodes are forwarded unchanged; no decoding or legality check. Arithmetic wraps at WIDTH bits in the alu.
//  alu_a/alu_b/alu_s keep the last issued values in IDLE/RESP (no toggling when idle).
//  Requester drops req_valid while not granted: no effect, nothing latched.
// STRUCTURE
//  Shared package alu_pkg: WIDTH default, opcode localparams (OP_ADD=4'b1111, OP_SUB=4'b1110,
//   OP_AND=4'b1101, OP_OR=4'b1100, OP_MUL=4'b0001, OP_SHL=4'b1010, OP_SHR=4'b1011, OP_SLT=4'b1000, OP_SGT=4'b1001),
//   FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
//  Sub-module rr_arbiter2: inputs req[1:0], pointer; output grant[1:0] one-hot; pointer register stays in parent.
//  Bench instantiates alu_req_arbiter with the real alu attached.
// TESTING
//  1 Req0 only: a=5,b=3,op=OP_ADD, accept at T -> resp_valid=2'b01 at T+2, resp_result=8, resp_zero=0.
//  2 Both valid after reset: req0 SUB 7-7, req1 OR 0x00F0|0x0F00 -> req0 served first (result 0, zero=1),
//    then req1 (0x0FF0); a third round with both valid grants req0 again.
//  3 Back-pressure: resp_ready held 0 for 10 cycles -> resp_valid, resp_result stable, req_ready=0, busy=1;
//    resp_ready=1 -> IDLE next cycle.
//  4 Reset asserted in WAIT and in RESP -> next cycle all outputs at reset values, no resp_valid pulse afterwards.
//  5 SETTLE_CYCLES=3, MUL 0x0100*0x0100 -> resp at T+4, resp_result=0x0000, resp_zero=1 (wrap).
//  6 Idle hold: after op SHL a=1,b=4 (result 16) -> alu_a/alu_b/alu_s unchanged while req_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu request arbiter: data width, alu opcode
// encodings and the arbiter FSM state encoding.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_AND = 4'b1101;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SGT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_rr.sv
// Two-way round-robin grant logic; the pointer register lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational alu between two requesters with round-robin
// arbitration, registered alu operands and a settle delay before capture.
module alu_req_arbiter #(
  parameter int WIDTH         = alu_pkg::WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  import alu_pkg::*;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           r_state;
  logic             r_pointer;
  logic             r_owner;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_s;
  logic [1:0]       r_resp_valid;
  logic [WIDTH-1:0] r_resp_result;
  logic             r_resp_zero;

  logic [1:0]       w_grant;
  logic             w_grant_idx;

  rr_arbiter2 u_rr (
    .req     (req_valid),
    .pointer (r_pointer),
    .grant   (w_grant)
  );

  assign w_grant_idx = w_grant[1];

  // Grant is only visible while idle, so at most one op is ever outstanding.
  assign req_ready   = (r_state == IDLE) ? w_grant : 2'b00;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_s       = r_alu_s;
  assign busy        = (r_state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pointer     <= 1'b0;
      r_owner       <= 1'b0;
      r_count       <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_s       <= 4'b0000;
      r_resp_valid  <= 2'b00;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_owner   <= w_grant_idx;
            r_pointer <= ~w_grant_idx;
            r_alu_a   <= w_grant_idx ? req1_a  : req0_a;
            r_alu_b   <= w_grant_idx ? req1_b  : req0_b;
            r_alu_s   <= w_grant_idx ? req1_op : req0_op;
            r_count   <= CW'(SETTLE_CYCLES - 1);
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_count == '0) begin
            r_resp_result <= alu_result;
            r_resp_zero   <= (alu_result == '0);
            r_resp_valid  <= r_owner ? 2'b10 : 2'b01;
            r_state       <= RESP;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready[r_owner]) begin
            r_resp_valid <= 2'b00;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
